lcd_bus_arbiter: RTL and testbench

//  Shares the single LCD byte-write channel (low-level LCD write FSM: d/rs + valid/busy) among N_REQ clients.

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/lcd_bus_arbiter_rr_picker.sv | 32 +++
 rtl/lcd_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: arbiter state encoding and the HD44780 command bytes
// used by both the bus arbiter and the LCD controller.
package lcd_pkg;

    typedef enum logic [1:0] {
        POR_WAIT = 2'd0,
        INIT     = 2'd1,
        IDLE     = 2'd2,
        XFER     = 2'd3
    } arb_state_t;

    localparam logic [7:0] LCD_CMD_FUNC_SET   = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPLAY_ON = 8'h0C;
    localparam logic [7:0] LCD_CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME       = 8'h02;

    localparam int LCD_INIT_LEN = 4;

    // 8-bit bus, 2 lines; display on, cursor off; increment; clear
    localparam logic [7:0] LCD_INIT_ROM [LCD_INIT_LEN] = '{
        LCD_CMD_FUNC_SET,
        LCD_CMD_DISPLAY_ON,
        LCD_CMD_ENTRY_MODE,
        LCD_CMD_CLEAR
    };

    function automatic logic [7:0] init_rom_byte(input logic [1:0] idx);
        return LCD_INIT_ROM[idx];
    endfunction

endpackage

// File: rtl/lcd_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: selects the first asserted request at or
// after ptr, wrapping around, as both a one-hot vector and an index.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from ptr; once a requester is taken, later candidates are masked
    always_comb begin : p_pick
        int   cand;
        logic take;
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        take = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            cand       = (int'(ptr) + off) % N_REQ;
            take       = !any && req[cand];
            pick[cand] = take;
            idx        = take ? IDX_W'(cand) : idx;
            any        = any | take;
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares the LCD byte-write channel among N_REQ clients: runs the HD44780
// power-up init, then grants whole transactions round-robin.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int POR_CYCLES   = 750000,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_rs,
    input  logic [8*N_REQ-1:0]   req_d,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     grant,
    output logic                 abort,
    output logic                 init_done,
    output logic                 lcd_valid,
    output logic                 lcd_rs,
    output logic [7:0]           lcd_d,
    input  logic                 lcd_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int POR_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
    localparam int TO_W  = $clog2(IDLE_TIMEOUT + 1);

    arb_state_t         state_q, state_d;
    logic [POR_W-1:0]   por_cnt_q, por_cnt_d;
    logic [1:0]         rom_idx_q, rom_idx_d;
    logic [TO_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               abort_q, abort_d;
    logic               init_done_q, init_done_d;

    logic [N_REQ-1:0]   pick_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_any_s;
    logic               xfer_s;
    logic [IDX_W-1:0]   next_ptr_s;
    logic [7:0]         req_bytes_s [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
        assign req_bytes_s[i] = req_d[i*8 +: 8];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick_s),
        .idx  (pick_idx_s),
        .any  (pick_any_s)
    );

    assign xfer_s     = lcd_valid & ~lcd_busy;
    assign next_ptr_s = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

    assign grant     = grant_q;
    assign abort     = abort_q;
    assign init_done = init_done_q;

    // Channel mux: in XFER the granted client drives the LCD side directly
    always_comb begin
        lcd_valid = 1'b0;
        lcd_rs    = 1'b0;
        lcd_d     = 8'h00;
        ack       = '0;
        case (state_q)
            INIT: begin
                lcd_valid = 1'b1;
                lcd_d     = init_rom_byte(rom_idx_q);
            end
            XFER: begin
                lcd_valid = req[gidx_q];
                lcd_rs    = req_rs[gidx_q];
                lcd_d     = req_bytes_s[gidx_q];
                ack       = grant_q & {N_REQ{req[gidx_q] & ~lcd_busy}};
            end
            default: begin
            end
        endcase
    end

    // Next-state logic; the idle counter only advances while req[g] is low,
    // so a stalled LCD (busy) never causes a forced release
    always_comb begin
        state_d     = state_q;
        por_cnt_d   = por_cnt_q;
        rom_idx_d   = rom_idx_q;
        idle_cnt_d  = idle_cnt_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        abort_d     = 1'b0;
        init_done_d = init_done_q;
        case (state_q)
            POR_WAIT: begin
                if (por_cnt_q == POR_W'(POR_CYCLES - 1)) begin
                    state_d   = INIT;
                    por_cnt_d = '0;
                end else begin
                    por_cnt_d = por_cnt_q + POR_W'(1);
                end
            end
            INIT: begin
                if (xfer_s) begin
                    if (rom_idx_q == 2'd3) begin
                        state_d     = IDLE;
                        rom_idx_d   = 2'd0;
                        init_done_d = 1'b1;
                    end else begin
                        rom_idx_d = rom_idx_q + 2'd1;
                    end
                end else begin
                    rom_idx_d = rom_idx_q;
                end
            end
            IDLE: begin
                idle_cnt_d = '0;
                if (pick_any_s) begin
                    state_d = XFER;
                    grant_d = pick_s;
                    gidx_d  = pick_idx_s;
                end else begin
                    grant_d = '0;
                end
            end
            XFER: begin
                if (xfer_s && req_last[gidx_q]) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    ptr_d      = next_ptr_s;
                    idle_cnt_d = '0;
                end else if (!req[gidx_q]) begin
                    if (idle_cnt_q == TO_W'(IDLE_TIMEOUT - 1)) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        ptr_d      = next_ptr_s;
                        abort_d    = 1'b1;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + TO_W'(1);
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            default: begin
                state_d = POR_WAIT;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= POR_WAIT;
            por_cnt_q   <= '0;
            rom_idx_q   <= 2'd0;
            idle_cnt_q  <= '0;
            ptr_q       <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            abort_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            por_cnt_q   <= por_cnt_d;
            rom_idx_q   <= rom_idx_d;
            idle_cnt_q  <= idle_cnt_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            abort_q     <= abort_d;
            init_done_q <= init_done_d;
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter. Observed vector layout:
// {grant[3:0], ack[3:0], abort, init_done, lcd_valid, lcd_rs, lcd_d[7:0]}.
module tb_lcd_bus_arbiter;

    localparam int N   = 4;
    localparam int POR = 20;
    localparam int TO  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req, req_rs, req_last;
    logic [8*N-1:0] req_d;
    logic          lcd_busy;
    logic [N-1:0]  ack, grant;
    logic          abort, init_done, lcd_valid, lcd_rs;
    logic [7:0]    lcd_d;

    int n_cmp = 0;
    int n_err = 0;

    wire [19:0] obs = {grant, ack, abort, init_done, lcd_valid, lcd_rs, lcd_d};

    lcd_bus_arbiter #(
        .N_REQ        (N),
        .POR_CYCLES   (POR),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_rs    (req_rs),
        .req_d     (req_d),
        .req_last  (req_last),
        .ack       (ack),
        .grant     (grant),
        .abort     (abort),
        .init_done (init_done),
        .lcd_valid (lcd_valid),
        .lcd_rs    (lcd_rs),
        .lcd_d     (lcd_d),
        .lcd_busy  (lcd_busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = '0; req_rs = '0; req_last = '0; req_d = '0; lcd_busy = 1'b0;
        step; step;
        n_cmp++;
        if (obs !== 20'h00000) begin n_err++; $display("FAIL reset_outputs got %h exp %h", obs, 20'h00000); end
        reset = 1'b0;
        for (int c = 1; c <= POR; c++) begin
            step;
            if (c == POR - 1) begin
                n_cmp++;
                if (obs !== 20'h00000) begin n_err++; $display("FAIL por_wait_quiet got %h exp %h", obs, 20'h00000); end
            end
        end
        n_cmp++;
        if (obs !== 20'h00238) begin n_err++; $display("FAIL init_first_byte got %h exp %h", obs, 20'h00238); end
    endtask

    task automatic test_init;
        logic [7:0] rom [3] = '{8'h0C, 8'h06, 8'h01};
        logic [19:0] e;
        for (int i = 0; i < 3; i++) begin
            step;
            e = {8'h00, 4'h2, rom[i]};
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL init_byte%0d got %h exp %h", i + 1, obs, e); end
        end
        step;
        n_cmp++;
        if (obs !== 20'h00400) begin n_err++; $display("FAIL init_done got %h exp %h", obs, 20'h00400); end
    endtask

    task automatic test_multi_byte;
        logic [7:0] bytes [3] = '{8'hA1, 8'hA2, 8'hA3};
        logic [19:0] e;
        req = 4'b0010; req_rs = 4'b0010; req_last = 4'b0000; req_d[15:8] = bytes[0];
        #1;
        n_cmp++;
        if (obs !== 20'h00400) begin n_err++; $display("FAIL mb_no_grant_yet got %h exp %h", obs, 20'h00400); end
        step;
        for (int b = 0; b < 3; b++) begin
            req_d[15:8] = bytes[b];
            req_last[1] = (b == 2);
            #1;
            e = {4'b0010, 4'b0010, 4'h7, bytes[b]};
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL mb_byte%0d got %h exp %h", b, obs, e); end
            step;
        end
        n_cmp++;
        if (obs !== 20'h00400) begin n_err++; $display("FAIL mb_release got %h exp %h", obs, 20'h00400); end
        req = '0; req_last = '0; req_rs = '0;
    endtask

    task automatic test_back_to_back;
        logic [3:0] g;
        logic [7:0] d;
        logic [19:0] e;
        req = 4'b0101; req_last = 4'b1111; req_rs = 4'b0000;
        req_d[7:0] = 8'h50; req_d[23:16] = 8'h52;
        // Pointer sits after client 1, so client 2 wins first
        for (int t = 0; t < 4; t++) begin
            step;
            g = (t % 2 == 0) ? 4'b0100 : 4'b0001;
            d = (t % 2 == 0) ? 8'h52 : 8'h50;
            e = {g, g, 4'h6, d};
            n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL alt_grant%0d got %h exp %h", t, obs, e); end
            step;
            n_cmp++;
            if (obs !== 20'h00400) begin n_err++; $display("FAIL alt_gap%0d got %h exp %h", t, obs, 20'h00400); end
        end
        req = '0; req_last = '0;
    endtask

    task automatic test_busy;
        lcd_busy = 1'b1;
        req = 4'b0010; req_rs = 4'b0000; req_last = 4'b0010; req_d[15:8] = 8'h77;
        step;
        n_cmp++;
        if (obs !== 20'h20677) begin n_err++; $display("FAIL busy_grant got %h exp %h", obs, 20'h20677); end
        for (int i = 1; i < 10; i++) begin
            step;
            n_cmp++;
            if (obs !== 20'h20677) begin n_err++; $display("FAIL busy_hold%0d got %h exp %h", i, obs, 20'h20677); end
        end
        lcd_busy = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 20'h22677) begin n_err++; $display("FAIL busy_fall_ack got %h exp %h", obs, 20'h22677); end
        step;
        n_cmp++;
        if (obs !== 20'h00400) begin n_err++; $display("FAIL busy_done got %h exp %h", obs, 20'h00400); end
        req = '0; req_last = '0;
    endtask

    task automatic test_timeout;
        req = 4'b1000; req_rs = 4'b0000; req_last = 4'b0000; req_d[31:24] = 8'h33;
        step;
        n_cmp++;
        if (obs !== 20'h88633) begin n_err++; $display("FAIL to_grant got %h exp %h", obs, 20'h88633); end
        step;
        req = 4'b0001; req_last = 4'b0001; req_d[7:0] = 8'h44;
        #1;
        n_cmp++;
        if (obs !== 20'h80433) begin n_err++; $display("FAIL to_others_ignored got %h exp %h", obs, 20'h80433); end
        for (int i = 1; i <= TO; i++) begin
            step;
            if (i < TO) begin
                n_cmp++;
                if (obs !== 20'h80433) begin n_err++; $display("FAIL to_wait%0d got %h exp %h", i, obs, 20'h80433); end
            end else begin
                n_cmp++;
                if (obs !== 20'h00C00) begin n_err++; $display("FAIL to_abort got %h exp %h", obs, 20'h00C00); end
            end
        end
        step;
        n_cmp++;
        if (obs !== 20'h11644) begin n_err++; $display("FAIL to_next_grant got %h exp %h", obs, 20'h11644); end
        step;
        n_cmp++;
        if (obs !== 20'h00400) begin n_err++; $display("FAIL to_next_done got %h exp %h", obs, 20'h00400); end
        req = '0; req_last = '0;
    endtask

    task automatic test_reset_mid;
        req = 4'b0100; req_rs = 4'b0100; req_last = 4'b0000; req_d[23:16] = 8'h5A;
        step;
        n_cmp++;
        if (obs !== 20'h4475A) begin n_err++; $display("FAIL mid_grant got %h exp %h", obs, 20'h4475A); end
        reset = 1'b1;
        step;
        n_cmp++;
        if (obs !== 20'h00000) begin n_err++; $display("FAIL mid_reset got %h exp %h", obs, 20'h00000); end
        reset = 1'b0; req = '0; req_rs = '0;
        for (int c = 1; c <= POR; c++) begin
            step;
        end
        n_cmp++;
        if (obs !== 20'h00238) begin n_err++; $display("FAIL mid_replay got %h exp %h", obs, 20'h00238); end
        for (int i = 0; i < 4; i++) begin
            step;
        end
        n_cmp++;
        if (obs !== 20'h00400) begin n_err++; $display("FAIL mid_init_done got %h exp %h", obs, 20'h00400); end
    endtask

    initial begin
        test_reset;
        test_init;
        test_multi_byte;
        test_back_to_back;
        test_busy;
        test_timeout;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
